data_mem_responder: RTL and testbench

- Memory-side responder for the core's load/store port: accepts one request (address, write data, funct3, write flag) and returns read data or performs the store after a programmable number of wait states.
- Sits between the datapath's address/writeData/readData/f3 signals and a word-organised RAM array held inside the block.
- Handles byte/half/word lanes, little-endian, load sign/zero extension and misalignment errors, so the core stays single-cycle-clean when wait states are added.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/lsu_align.sv | 61 ++++++
 rtl/data_mem_responder.sv | 152 +++++++++++++++
 tb/tb_data_mem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the data-memory responder and its lane aligner.
package mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned LANES  = WORD_W / LANE_W;
    localparam int unsigned CNT_W  = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enables/shifted data, load extension, error flag.
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]        f3_i,
    input  logic [1:0]        addr_lo_i,
    input  logic              we_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [WORD_W-1:0] rword_i,
    output logic [LANES-1:0]  be_o,
    output logic [WORD_W-1:0] wword_o,
    output logic [WORD_W-1:0] load_o,
    output logic              err_o
);

    logic [LANE_W-1:0]   byte_c;
    logic [2*LANE_W-1:0] half_c;

    assign byte_c = rword_i[{addr_lo_i, 3'b000} +: LANE_W];
    assign half_c = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    // err_o covers both misalignment and f3 codes that are illegal for the access direction
    always_comb begin
        be_o    = '0;
        wword_o = '0;
        load_o  = '0;
        err_o   = 1'b0;
        case (f3_i)
            F3_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
                load_o  = {{24{byte_c[7]}}, byte_c};
            end
            F3_H: begin
                err_o   = addr_lo_i[0];
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
                load_o  = {{16{half_c[15]}}, half_c};
            end
            F3_W: begin
                err_o   = (addr_lo_i != 2'b00);
                be_o    = 4'b1111;
                wword_o = wdata_i;
                load_o  = rword_i;
            end
            F3_BU: begin
                err_o  = we_i;
                load_o = {24'h0, byte_c};
            end
            F3_HU: begin
                err_o  = we_i | addr_lo_i[0];
                load_o = {16'h0, half_c};
            end
            default: err_o = 1'b1;
        endcase
        if (err_o || !we_i) begin
            be_o = '0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one request at a time, programmable wait states, word RAM inside.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [2:0]        f3,
    output logic              ready,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;

    logic [IDX_W-1:0]  idx_c;
    logic [WORD_W-1:0] rword_c, wword_c, load_c, wmerge_c;
    logic [LANES-1:0]  be_c;
    logic              aerr_c;
    logic              access_c;

    assign idx_c    = IDX_W'(addr_q[ADDR_W-1:2]);
    assign rword_c  = mem_q[idx_c];
    assign access_c = (state_q == WAIT) && (cnt_q == '0);

    lsu_align u_align (
        .f3_i     (f3_q),
        .addr_lo_i(addr_q[1:0]),
        .we_i     (we_q),
        .wdata_i  (wdata_q),
        .rword_i  (rword_c),
        .be_o     (be_c),
        .wword_o  (wword_c),
        .load_o   (load_c),
        .err_o    (aerr_c)
    );

    // Read-modify-write merge keeps unselected lanes intact
    always_comb begin
        wmerge_c = rword_c;
        for (int i = 0; i < int'(LANES); i++) begin
            if (be_c[i]) wmerge_c[i*LANE_W +: LANE_W] = wword_c[i*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && access_c && we_q && !aerr_c) begin
            mem_q[idx_c] <= wmerge_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(LATENCY);
                end
            end
            WAIT: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                else             state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        ready_d = 1'b0;
        err_d   = err_q;
        rdata_d = rdata_q;
        busy_d  = (state_d != IDLE);
        if (state_q == IDLE && req) begin
            we_d    = we;
            addr_d  = addr;
            wdata_d = wdata;
            f3_d    = f3;
        end
        if (access_c) begin
            ready_d = 1'b1;
            err_d   = aerr_c;
            rdata_d = (aerr_c || we_q) ? '0 : load_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    assign ready = ready_q;
    assign rdata = rdata_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 instance (index 0) and LATENCY=0 instance (index 1).
module tb_data_mem_responder;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 17;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [15:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [2:0]  f3_s    [2];
    logic        ready_s [2];
    logic [31:0] rdata_s [2];
    logic        err_s   [2];
    logic        busy_s  [2];

    logic [7:0]  mdl [2][4096];
    vec_t        vecs [NV];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .f3(f3_s[0]), .ready(ready_s[0]), .rdata(rdata_s[0]),
        .err(err_s[0]), .busy(busy_s[0])
    );

    data_mem_responder #(.LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst(rst), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .f3(f3_s[1]), .ready(ready_s[1]), .rdata(rdata_s[1]),
        .err(err_s[1]), .busy(busy_s[1])
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Byte-addressed reference: the array is seen as 4096 bytes with the word index wrapping
    task automatic model(input int s, input logic w, input logic [15:0] a, input logic [31:0] d,
                         input logic [2:0] f, output logic [31:0] er, output logic ee);
        int base, off, size;
        bit legal;
        base = ((int'(a) / 4) % 1024) * 4;
        off  = int'(a) % 4;
        size = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        legal = w ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
        ee = !legal || (off % size != 0);
        er = '0;
        if (!ee) begin
            if (w) begin
                for (int i = 0; i < size; i++) mdl[s][base + off + i] = d[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++) er[8*i +: 8] = mdl[s][base + off + i];
                if (!f[2] && size == 1 && er[7])  er = er | 32'hFFFF_FF00;
                if (!f[2] && size == 2 && er[15]) er = er | 32'hFFFF_0000;
            end
        end
    endtask

    task automatic run_txn(input int s, input logic w, input logic [15:0] a, input logic [31:0] d,
                           input logic [2:0] f, input logic [31:0] er, input logic ee,
                           input string nm);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        @(negedge clk);
        req_s[s] = 1'b1; we_s[s] = w; addr_s[s] = a; wdata_s[s] = d; f3_s[s] = f;
        @(posedge clk); #1;
        req_s[s] = 1'b0;
        chk({nm, "_busy_wait"}, 32'(busy_s[s]), 32'd1);
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ready_s[s]) seen = 1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got=no_ready exp=ready", nm);
        end else begin
            chk({nm, "_lat"}, 32'(n), (s == 0) ? 32'd3 : 32'd1);
            chk({nm, "_rdata"}, rdata_s[s], er);
            chk({nm, "_err"}, 32'(err_s[s]), 32'(ee));
            chk({nm, "_busy_resp"}, 32'(busy_s[s]), 32'd1);
            @(posedge clk); #1;
            chk({nm, "_ready_drop"}, 32'(ready_s[s]), 32'd0);
            chk({nm, "_busy_drop"}, 32'(busy_s[s]), 32'd0);
            chk({nm, "_rdata_hold"}, rdata_s[s], er);
        end
    endtask

    task automatic setv(input int i, input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [2:0] f, input logic [31:0] er, input logic ee);
        vecs[i] = '{w, a, d, f, er, ee};
    endtask

    initial begin
        logic [31:0] mr, got;
        logic        me;
        int          pulses;
        logic        rw;
        logic [15:0] ra;
        logic [31:0] rd;
        logic [2:0]  rf;

        for (int s = 0; s < 2; s++) begin
            req_s[s] = 0; we_s[s] = 0; addr_s[s] = 0; wdata_s[s] = 0; f3_s[s] = 0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            for (int s = 0; s < 2; s++) begin
                chk("idle_ready", 32'(ready_s[s]), 32'd0);
                chk("idle_busy", 32'(busy_s[s]), 32'd0);
                chk("idle_rdata", rdata_s[s], 32'd0);
                chk("idle_err", 32'(err_s[s]), 32'd0);
            end
        end

        setv(0,  1, 16'h0010, 32'hDEAD_BEEF, 3'b010, 32'h0000_0000, 0);
        setv(1,  0, 16'h0010, 32'h0,         3'b010, 32'hDEAD_BEEF, 0);
        setv(2,  1, 16'h0020, 32'h0,         3'b010, 32'h0000_0000, 0);
        setv(3,  1, 16'h0023, 32'h0000_0080, 3'b000, 32'h0000_0000, 0);
        setv(4,  0, 16'h0023, 32'h0,         3'b000, 32'hFFFF_FF80, 0);
        setv(5,  0, 16'h0023, 32'h0,         3'b100, 32'h0000_0080, 0);
        setv(6,  0, 16'h0020, 32'h0,         3'b010, 32'h8000_0000, 0);
        setv(7,  1, 16'h0020, 32'h0000_1234, 3'b001, 32'h0000_0000, 0);
        setv(8,  0, 16'h0020, 32'h0,         3'b101, 32'h0000_1234, 0);
        setv(9,  0, 16'h0012, 32'h0,         3'b010, 32'h0000_0000, 1);
        setv(10, 1, 16'h0021, 32'h0000_FFFF, 3'b001, 32'h0000_0000, 1);
        setv(11, 0, 16'h0020, 32'h0,         3'b010, 32'h8000_1234, 0);
        setv(12, 0, 16'h0022, 32'h0,         3'b001, 32'hFFFF_8000, 0);
        setv(13, 0, 16'h0020, 32'h0,         3'b011, 32'h0000_0000, 1);
        setv(14, 1, 16'h0020, 32'h0000_00FF, 3'b100, 32'h0000_0000, 1);
        setv(15, 0, 16'h0020, 32'h0,         3'b010, 32'h8000_1234, 0);
        setv(16, 1, 16'h0040, 32'h2222_2222, 3'b010, 32'h0000_0000, 0);

        for (int i = 0; i < NV; i++) begin
            model(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, mr, me);
            run_txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3,
                    vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // A store request raised during WAIT must be ignored entirely
        @(negedge clk);
        req_s[0] = 1; we_s[0] = 0; addr_s[0] = 16'h0010; f3_s[0] = 3'b010;
        @(posedge clk); #1 req_s[0] = 0;
        @(negedge clk);
        req_s[0] = 1; we_s[0] = 1; wdata_s[0] = 32'h0; addr_s[0] = 16'h0010;
        @(negedge clk);
        req_s[0] = 0; we_s[0] = 0;
        pulses = 0;
        got = '0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (ready_s[0]) begin
                pulses++;
                got = rdata_s[0];
            end
        end
        chk("ignore_pulses", 32'(pulses), 32'd1);
        chk("ignore_rdata", got, 32'hDEAD_BEEF);
        run_txn(0, 0, 16'h0010, 32'h0, 3'b010, 32'hDEAD_BEEF, 0, "ignore_lw");

        // Reset during WAIT drops the store and suppresses ready
        @(negedge clk);
        req_s[0] = 1; we_s[0] = 1; addr_s[0] = 16'h0040; wdata_s[0] = 32'h1111_1111; f3_s[0] = 3'b010;
        @(posedge clk); #1 req_s[0] = 0; we_s[0] = 0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (ready_s[0]) pulses++;
        end
        chk("rstmid_pulses", 32'(pulses), 32'd0);
        chk("rstmid_busy", 32'(busy_s[0]), 32'd0);
        run_txn(0, 0, 16'h0040, 32'h0, 3'b010, 32'h2222_2222, 0, "rstmid_lw");

        model(1, 1, 16'h1004, 32'hA5A5_A5A5, 3'b010, mr, me);
        run_txn(1, 1, 16'h1004, 32'hA5A5_A5A5, 3'b010, 32'h0, 0, "wrap_sw");
        model(1, 0, 16'h0004, 32'h0, 3'b010, mr, me);
        run_txn(1, 0, 16'h0004, 32'h0, 3'b010, 32'hA5A5_A5A5, 0, "wrap_lw");

        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) begin
                rd = $urandom;
                model(s, 1, 16'(w * 4), rd, 3'b010, mr, me);
                run_txn(s, 1, 16'(w * 4), rd, 3'b010, mr, me, "fill");
            end
            for (int t = 0; t < 120; t++) begin
                rw = 1'($urandom_range(0, 1));
                ra = 16'(($urandom_range(0, 15) << 12) | $urandom_range(0, 63));
                rd = $urandom;
                rf = 3'($urandom_range(0, 7));
                model(s, rw, ra, rd, rf, mr, me);
                run_txn(s, rw, ra, rd, rf, mr, me, $sformatf("rnd%0d_%0d", s, t));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
